alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, handshaked successor of the 4-bit ALU. Arithmetic/logic ops complete in one
//  cycle; shift/rotate by a variable amount run serially, one bit per cycle, via an FSM.
//  Registered result plus four flags, held until consumed. Sits between the operand-issue
//  logic and the writeback stage, with valid/ready on both sides.
// PARAMETERS
//  WIDTH    8                 operand/result width in bits (>=2)
//  SHAMT_W  $clog2(WIDTH)     width of shift amount taken from b[SHAMT_W-1:0]
// PORTS
//  clk        in   1        clock; all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operation request valid
//  in_ready   out  1        block can accept a request this cycle
//  op         in   3        opcode (see BEHAVIOUR)
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B / shift amount in b[SHAMT_W-1:0]
//  out_valid  out  1        result and flags valid
//  out_ready  in   1        consumer accepts result
//  result     out  WIDTH    operation result
//  carry      out  1        carry / borrow / last bit shifted out
//  zero       out  1        result == 0
//  neg        out  1        result[WIDTH-1]
//  ovf        out  1        signed overflow (ADD/SUB only)
// BEHAVIOUR
//  Reset (async on rst_n low, held while low): state=IDLE; out_valid, result, carry, zero,
//   neg, ovf all 0; shift counter 0. Any op in flight is discarded; no output for it.
//  Opcodes: 000 ADD, 001 SUB, 010 SHL (logical left, shift in 0), 011 ROL, 100 AND,
//   101 OR, 110 XOR, 111 reserved (result 0, carry 0, ovf 0, zero 1).
//  Accept: transfer when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
//   Operands/op latched at accept; later changes on a/b/op are ignored.
//  FSM: IDLE -> (accept, op in {SHL,ROL}, amt!=0) SHIFT; IDLE -> (other accept) IDLE with out_valid=1.
//   SHIFT: work reg shifts/rotates one bit per cycle, counter decrements; at count 0 -> IDLE,
//   out_valid=1 that same edge. Shift ops with amt=0: complete like single-cycle op, result=a, carry=0.
//  Latency (accept edge to out_valid high): 1 cycle single-cycle ops; amt+1 cycles SHL/ROL with amt>0.
//   Back-to-back single-cycle ops sustain 1 op/cycle when out_ready held high.
//  Output hold: result/flags/out_valid stable while out_valid && !out_ready. out_valid drops the edge
//   after out_valid && out_ready unless a new result is written on that same edge.
//  Arithmetic (unsigned width rules):
//   ADD: {carry,result} = a + b (WIDTH+1 bits); ovf = a,b same sign && result sign differs.
//   SUB: {carry,result} = {1'b0,a} - {1'b0,b}; carry=1 means borrow (a<b unsigned);
//        ovf = a,b differ in sign && result sign differs from a.
//   SHL: carry = last bit shifted out of MSB. ROL: carry=0. Logic ops: carry=0. ovf=0 except ADD/SUB.
//   amt >= WIDTH (when SHAMT_W permits): SHL gives 0; ROL wraps (amt mod WIDTH net rotation).
//  zero, neg always derived from final result, registered with it.
// TESTING (WIDTH=8)
//  Reset mid-SHIFT (SHL a=0x81 amt=5, rst_n low at cycle 2) -> all outputs 0, in_ready=1 after release, no stale out_valid.
//  ADD 0xFF+0x01 -> result 0x00, carry 1, zero 1, ovf 0; ADD 0x7F+0x01 -> 0x80, neg 1, ovf 1, latency 1.
//  SUB 0x03-0x05 -> result 0xFE, carry(borrow) 1, neg 1, ovf 0; SUB 0x80-0x01 -> 0x7F, ovf 1.
//  SHL a=0xC1 amt=3 -> result 0x08, carry 0 (last out bit), out_valid 4 cycles after accept; in_ready 0 meanwhile.
//  ROL a=0x81 amt=1 -> 0x03; amt=0 -> 0x81, latency 1; op=111 -> 0x00, zero 1.
//  Backpressure: out_ready=0 for 5 cycles after ADD result -> outputs held, in_ready 0; release -> next op accepted same cycle.

Source files
------------

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - handshaked ALU with single-cycle arith/logic and serial shift/rotate
// SHL/ROL with a nonzero amount step one bit per cycle in the SHIFT state; all other ops register in one edge.
module alu_seq_core #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic               rol_q, rol_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [SHAMT_W-1:0] amt;
  logic               is_shift_op;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic [WIDTH-1:0]   work_step;
  logic               load;
  logic [WIDTH-1:0]   ld_res;
  logic               ld_carry;
  logic               ld_ovf;

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign amt         = b[SHAMT_W-1:0];
  assign is_shift_op = (op == OP_SHL) || (op == OP_ROL);

  // ROL feeds the MSB back in; SHL feeds a zero.
  assign work_step = {work_q[WIDTH-2:0], rol_q & work_q[WIDTH-1]};

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL:  alu_res = a;
      OP_ROL:  alu_res = a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    rol_d       = rol_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    load        = 1'b0;
    ld_res      = '0;
    ld_carry    = 1'b0;
    ld_ovf      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op && (amt != '0)) begin
            state_d = ST_SHIFT;
            cnt_d   = amt;
            work_d  = a;
            rol_d   = (op == OP_ROL);
          end else begin
            load     = 1'b1;
            ld_res   = alu_res;
            ld_carry = alu_carry;
            ld_ovf   = alu_ovf;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - CNT_ONE;
        // The final step writes the output directly so latency is amt+1.
        if (cnt_q == CNT_ONE) begin
          state_d  = ST_IDLE;
          load     = 1'b1;
          ld_res   = work_step;
          ld_carry = !rol_q && work_q[WIDTH-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      result_d    = ld_res;
      carry_d     = ld_carry;
      ovf_d       = ld_ovf;
      zero_d      = (ld_res == '0);
      neg_d       = ld_res[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      rol_q       <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      rol_q       <= rol_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - scoreboard bench for alu_seq_core (WIDTH=8)
// Stimulus pushes model results into a queue; the monitor pops and compares on each output handshake.
module tb_alu_seq_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         neg;
  logic         ovf;

  int   rdy_mode = 0;
  logic rdy_val = 1'b1;
  logic rnd_ready = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    int         acc;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign out_ready = (rdy_mode == 1) ? rnd_ready : rdy_val;
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   s;
    int   amt;
    amt   = int'(y[2:0]);
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.res = 8'h00;
    e.acc = 0;
    e.lat = 1;
    case (o)
      3'd0: begin
        s     = int'(x) + int'(y);
        e.res = s[7:0];
        e.c   = (s > 255);
        s     = int'($signed(x)) + int'($signed(y));
        e.v   = (s > 127) || (s < -128);
      end
      3'd1: begin
        s     = int'(x) - int'(y);
        e.res = s[7:0];
        e.c   = (x < y);
        s     = int'($signed(x)) - int'($signed(y));
        e.v   = (s > 127) || (s < -128);
      end
      3'd2: begin
        s     = int'(x) << amt;
        e.res = s[7:0];
        e.c   = (amt != 0) ? s[8] : 1'b0;
        e.lat = (amt != 0) ? amt + 1 : 1;
      end
      3'd3: begin
        s     = (int'(x) << amt) | (int'(x) >> (8 - amt));
        e.res = s[7:0];
        e.lat = (amt != 0) ? amt + 1 : 1;
      end
      3'd4: e.res = x & y;
      3'd5: e.res = x | y;
      3'd6: e.res = x ^ y;
      default: e.res = 8'h00;
    endcase
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    return e;
  endfunction

  // Monitor: compares on handshake, checks latency and output stability under backpressure.
  logic [7:0] p_res;
  logic       p_c, p_z, p_n, p_v;
  logic       p_stall = 1'b0;
  int         first_seen = -1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      p_stall    = 1'b0;
      first_seen = -1;
    end else begin
      if (p_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, p_res);
        chk("hold_flags", {carry, zero, neg, ovf}, {p_c, p_z, p_n, p_v});
      end
      if (out_valid) begin
        if (first_seen < 0) first_seen = cyc;
        if (!out_ready) chk("stall_in_ready", in_ready, 0);
        if (out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got result %0h with empty scoreboard (cycle %0d)", result, cyc);
          end else begin
            e = sbq.pop_front();
            chk("result", result, e.res);
            chk("carry", carry, e.c);
            chk("zero", zero, e.z);
            chk("neg", neg, e.n);
            chk("ovf", ovf, e.v);
            chk("latency", first_seen - e.acc, e.lat);
          end
          first_seen = -1;
        end
      end
      p_stall = out_valid && !out_ready;
      p_res = result;
      p_c = carry;
      p_z = zero;
      p_n = neg;
      p_v = ovf;
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int waited);
    exp_t e;
    waited = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 1; k < e.lat; k++) begin
      @(negedge clk);
      chk("busy_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, {carry, zero, neg, ovf}, 4'b0000);
  endtask

  initial begin
    int w;
    logic [2:0] sc_ops[6];
    sc_ops = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    rdy_mode = 0;
    rdy_val = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_zero_outputs("reset");
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(3'd0, 8'hFF, 8'h01, w);
    issue(3'd0, 8'h7F, 8'h01, w);
    issue(3'd1, 8'h03, 8'h05, w);
    issue(3'd1, 8'h80, 8'h01, w);
    issue(3'd2, 8'hC1, 8'h03, w);
    issue(3'd3, 8'h81, 8'h01, w);
    issue(3'd3, 8'h81, 8'h00, w);
    issue(3'd7, 8'h5A, 8'hA5, w);
    issue(3'd2, 8'h81, 8'h07, w);
    issue(3'd3, 8'h96, 8'h07, w);
    wait_drain();

    for (int i = 0; i < 12; i++) begin
      issue(sc_ops[$urandom_range(0, 5)], 8'($urandom), 8'($urandom), w);
      chk("throughput_wait", w, 0);
    end
    wait_drain();

    rdy_val = 1'b0;
    issue(3'd0, 8'h10, 8'h20, w);
    in_valid = 1'b1;
    op = 3'd6;
    a = 8'h33;
    b = 8'h0F;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rdy_val = 1'b1;
    issue(3'd1, 8'h40, 8'h41, w);
    chk("accept_on_release", w, 0);
    wait_drain();

    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      issue(3'($urandom), 8'($urandom), 8'($urandom), w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rdy_mode = 0;
    rdy_val = 1'b1;
    wait_drain();

    in_valid = 1'b1;
    op = 3'd2;
    a = 8'h81;
    b = 8'h05;
    @(negedge clk);
    chk("rst_test_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midshift_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_reset_no_valid", out_valid, 0);
      chk("post_reset_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    issue(3'd0, 8'h12, 8'h34, w);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
